// File: rtl/bearcore_bus_pkg.sv
// rtl/bearcore_bus_pkg.sv - shared encodings and default widths for the memory port arbiter
package bearcore_bus_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational IF/LS winner selection
// LS wins by default; a starved IF overrides LS when both are pending.
module mem_arb_pick (
  input  logic if_valid_i,
  input  logic ls_valid_i,
  input  logic starved_i,
  output logic grant_if_o,
  output logic grant_ls_o
);

  assign grant_ls_o = ls_valid_i & ~(if_valid_i & starved_i);
  assign grant_if_o = if_valid_i & (~ls_valid_i | starved_i);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store
// One outstanding transaction; the response is routed back to the owner that issued it.
module mem_port_arbiter
  import bearcore_bus_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req_valid,
  output logic            if_req_ready,
  input  logic [AW-1:0]   if_addr,
  output logic            if_rsp_valid,
  output logic [DW-1:0]   if_rsp_data,
  input  logic            ls_req_valid,
  output logic            ls_req_ready,
  input  logic [AW-1:0]   ls_addr,
  input  logic            ls_we,
  input  logic [DW-1:0]   ls_wdata,
  input  logic [DW/8-1:0] ls_wstrb,
  output logic            ls_rsp_valid,
  output logic [DW-1:0]   ls_rsp_data,
  output logic            mem_req,
  input  logic            mem_gnt,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_we,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wstrb,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata,
  output logic            busy
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  owner_e        owner_q, owner_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          we_q, we_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          if_rsp_valid_q, if_rsp_valid_d;
  logic          ls_rsp_valid_q, ls_rsp_valid_d;
  logic [DW-1:0] if_rsp_data_q, if_rsp_data_d;
  logic [DW-1:0] ls_rsp_data_q, ls_rsp_data_d;

  logic grant_if, grant_ls, starved, can_accept;

  assign starved    = (starve_q == CW'(STARVE_MAX));
  // Readys are gated by rst_n so nothing is offered while reset is held.
  assign can_accept = rst_n & (state_q == ST_IDLE);

  mem_arb_pick u_pick (
    .if_valid_i (if_req_valid),
    .ls_valid_i (ls_req_valid),
    .starved_i  (starved),
    .grant_if_o (grant_if),
    .grant_ls_o (grant_ls)
  );

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    starve_d       = starve_q;
    if_rsp_valid_d = 1'b0;
    ls_rsp_valid_d = 1'b0;
    if_rsp_data_d  = if_rsp_data_q;
    ls_rsp_data_d  = ls_rsp_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_ls) begin
          state_d = ST_REQ;
          owner_d = OWN_LS;
          addr_d  = ls_addr;
          we_d    = ls_we;
          wdata_d = ls_wdata;
          wstrb_d = ls_wstrb;
          if (if_req_valid && !starved) starve_d = starve_q + CW'(1);
        end else if (grant_if) begin
          state_d  = ST_REQ;
          owner_d  = OWN_IF;
          addr_d   = if_addr;
          we_d     = 1'b0;
          wdata_d  = '0;
          wstrb_d  = '0;
          starve_d = '0;
        end
      end
      ST_REQ: begin
        if (mem_gnt) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_LS) begin
            ls_rsp_valid_d = 1'b1;
            ls_rsp_data_d  = we_q ? '0 : mem_rdata;
          end else begin
            if_rsp_valid_d = 1'b1;
            if_rsp_data_d  = mem_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      owner_q        <= OWN_IF;
      addr_q         <= '0;
      we_q           <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      starve_q       <= '0;
      if_rsp_valid_q <= 1'b0;
      ls_rsp_valid_q <= 1'b0;
      if_rsp_data_q  <= '0;
      ls_rsp_data_q  <= '0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      addr_q         <= addr_d;
      we_q           <= we_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      starve_q       <= starve_d;
      if_rsp_valid_q <= if_rsp_valid_d;
      ls_rsp_valid_q <= ls_rsp_valid_d;
      if_rsp_data_q  <= if_rsp_data_d;
      ls_rsp_data_q  <= ls_rsp_data_d;
    end
  end

  assign if_req_ready = can_accept & grant_if;
  assign ls_req_ready = can_accept & grant_ls;
  assign if_rsp_valid = if_rsp_valid_q;
  assign ls_rsp_valid = ls_rsp_valid_q;
  assign if_rsp_data  = if_rsp_data_q;
  assign ls_rsp_data  = ls_rsp_data_q;
  assign mem_req      = (state_q == ST_REQ);
  assign mem_addr     = addr_q;
  assign mem_we       = we_q;
  assign mem_wdata    = wdata_q;
  assign mem_wstrb    = wstrb_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req_valid = 1'b0, if_req_ready;
  logic [31:0] if_addr = '0;
  logic        if_rsp_valid;
  logic [31:0] if_rsp_data;
  logic        ls_req_valid = 1'b0, ls_req_ready;
  logic [31:0] ls_addr = '0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_wdata = '0;
  logic [3:0]  ls_wstrb = '0;
  logic        ls_rsp_valid;
  logic [31:0] ls_rsp_data;
  logic        mem_req, mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Reference model state: starvation count, pending response, last delivered data.
  int          starve_m = 0;
  bit          pend = 0;
  bit          pend_ls = 0;
  logic [31:0] pend_data = '0;
  logic [31:0] last_if = '0;
  logic [31:0] last_ls = '0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_rsp_valid(if_rsp_valid), .if_rsp_data(if_rsp_data),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_addr(ls_addr),
    .ls_we(ls_we), .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_data(ls_rsp_data),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic model_reset();
    starve_m = 0;
    pend     = 0;
    last_if  = '0;
    last_ls  = '0;
  endtask

  // Drives one complete transaction starting just after a clock edge with the DUT idle.
  task automatic do_txn(input logic iv, input logic lv, input logic [31:0] ia, input logic [31:0] la,
                        input logic we, input logic [31:0] wd, input logic [3:0] ws,
                        input logic [31:0] rdat, input int gd, input int rd, input bit hold);
    bit          own_ls;
    logic [31:0] ea;
    logic        ewe;
    logic [3:0]  ews;
    if_req_valid = iv; if_addr = ia;
    ls_req_valid = lv; ls_addr = la; ls_we = we; ls_wdata = wd; ls_wstrb = ws;
    if (lv && (!iv || starve_m < STARVE_MAX)) begin
      own_ls = 1;
      if (iv) starve_m++;
    end else begin
      own_ls = 0;
      starve_m = 0;
    end
    ea  = own_ls ? la : ia;
    ewe = own_ls ? we : 1'b0;
    ews = own_ls ? ws : 4'h0;
    @(negedge clk);
    if (pend) begin
      if (pend_ls) last_ls = pend_data; else last_if = pend_data;
    end
    checks++; if (if_rsp_valid !== (pend && !pend_ls)) begin errors++; $display("FAIL if_rsp_valid: got %b exp %b", if_rsp_valid, pend && !pend_ls); end
    checks++; if (ls_rsp_valid !== (pend && pend_ls)) begin errors++; $display("FAIL ls_rsp_valid: got %b exp %b", ls_rsp_valid, pend && pend_ls); end
    checks++; if (if_rsp_data !== last_if) begin errors++; $display("FAIL if_rsp_data: got %h exp %h", if_rsp_data, last_if); end
    checks++; if (ls_rsp_data !== last_ls) begin errors++; $display("FAIL ls_rsp_data: got %h exp %h", ls_rsp_data, last_ls); end
    checks++; if (if_req_ready !== !own_ls) begin errors++; $display("FAIL if_req_ready: got %b exp %b", if_req_ready, !own_ls); end
    checks++; if (ls_req_ready !== own_ls) begin errors++; $display("FAIL ls_req_ready: got %b exp %b", ls_req_ready, own_ls); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_idle: got %b exp 0", busy); end
    pend = 0;
    @(posedge clk); #1;
    if (!hold) begin if_req_valid = 0; ls_req_valid = 0; end
    for (int k = 0; k <= gd; k++) begin
      mem_gnt = (k == gd);
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mem_req_hi: got %b exp 1", mem_req); end
      checks++; if (mem_addr !== ea) begin errors++; $display("FAIL mem_addr: got %h exp %h", mem_addr, ea); end
      checks++; if (mem_we !== ewe) begin errors++; $display("FAIL mem_we: got %b exp %b", mem_we, ewe); end
      checks++; if (mem_wstrb !== ews) begin errors++; $display("FAIL mem_wstrb: got %h exp %h", mem_wstrb, ews); end
      if (ewe) begin
        checks++; if (mem_wdata !== wd) begin errors++; $display("FAIL mem_wdata: got %h exp %h", mem_wdata, wd); end
      end
      checks++; if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid} !== 4'b0) begin errors++; $display("FAIL req_phase_quiet: got %b exp 0000", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid}); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_req: got %b exp 1", busy); end
      @(posedge clk); #1;
    end
    mem_gnt = 0;
    for (int k = 0; k <= rd; k++) begin
      mem_rvalid = (k == rd);
      mem_rdata  = (k == rd) ? rdat : $urandom;
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mem_req_wait: got %b exp 0", mem_req); end
      checks++; if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, busy} !== 5'b00001) begin errors++; $display("FAIL wait_phase: got %b exp 00001", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, busy}); end
      @(posedge clk); #1;
    end
    mem_rvalid = 0;
    pend      = 1;
    pend_ls   = own_ls;
    pend_data = ewe ? 32'h0 : rdat;
  endtask

  // No request: deliver any pending response and confirm the pulse lasts one cycle.
  task automatic test_idle();
    if_req_valid = 0; ls_req_valid = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (pend) begin
        if (pend_ls) last_ls = pend_data; else last_if = pend_data;
      end
      checks++; if (if_rsp_valid !== (pend && !pend_ls)) begin errors++; $display("FAIL idle_if_rsp_valid: got %b exp %b", if_rsp_valid, pend && !pend_ls); end
      checks++; if (ls_rsp_valid !== (pend && pend_ls)) begin errors++; $display("FAIL idle_ls_rsp_valid: got %b exp %b", ls_rsp_valid, pend && pend_ls); end
      checks++; if ({if_rsp_data, ls_rsp_data} !== {last_if, last_ls}) begin errors++; $display("FAIL idle_rsp_data: got %h exp %h", {if_rsp_data, ls_rsp_data}, {last_if, last_ls}); end
      checks++; if ({if_req_ready, ls_req_ready, busy, mem_req} !== 4'b0) begin errors++; $display("FAIL idle_quiet: got %b exp 0000", {if_req_ready, ls_req_ready, busy, mem_req}); end
      pend = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 0; if_req_valid = 1; ls_req_valid = 1;
    if_addr = 32'h0000_0040; ls_addr = 32'h0000_0203; ls_we = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid, if_rsp_data, ls_rsp_data,
           mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb, busy} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h exp 0", {if_req_ready, ls_req_ready, if_rsp_valid, ls_rsp_valid,
                 if_rsp_data, ls_rsp_data, mem_req, mem_addr, mem_we, mem_wdata, mem_wstrb, busy});
      end
    end
    @(posedge clk); #1;
    rst_n = 1;
    model_reset();
    do_txn(1, 1, 32'h0000_0040, 32'h0000_0203, 0, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 0, 0);
  endtask

  task automatic test_single_fetch();
    do_txn(1, 0, 32'h0000_0010, 32'h0, 0, 32'h0, 4'h0, 32'h1234_50B7, 0, 0, 0);
    test_idle();
  endtask

  task automatic test_store();
    do_txn(0, 1, 32'h0, 32'h0000_0100, 1, 32'hDEAD_BEEF, 4'hF, 32'hCAFE_F00D, 0, 0, 0);
    test_idle();
  endtask

  task automatic test_starvation();
    for (int i = 0; i < 10; i++)
      do_txn(1, 1, 32'h1000 + 32'(i * 4), 32'h2000 + 32'(i * 4), 1'(i % 2), $urandom, 4'($urandom),
             $urandom, 0, 0, 1);
    test_idle();
  endtask

  task automatic test_stalled_memory();
    do_txn(0, 1, 32'h0, 32'h0000_0302, 0, 32'h0, 4'h0, 32'h5555_AAAA, 5, 2, 0);
    do_txn(1, 0, 32'h0000_0021, 32'h0, 0, 32'h0, 4'h0, 32'h7777_0001, 5, 0, 0);
    test_idle();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_txn(1'(i % 3 != 0), 1'(i % 3 != 2), $urandom, $urandom, 1'($urandom_range(0, 1)),
             $urandom, 4'($urandom), $urandom, 0, 0, 0);
    test_idle();
  endtask

  task automatic test_random();
    logic iv, lv;
    for (int i = 0; i < 40; i++) begin
      iv = 1'($urandom_range(0, 1));
      lv = 1'($urandom_range(0, 1));
      if (!iv && !lv) lv = 1;
      do_txn(iv, lv, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom,
             $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 4) == 0) test_idle();
    end
    test_idle();
  endtask

  task automatic test_reset_mid_wait();
    ls_req_valid = 1; ls_addr = 32'h0000_0404; ls_we = 0;
    @(negedge clk);
    checks++; if (ls_req_ready !== 1'b1) begin errors++; $display("FAIL midwait_accept: got %b exp 1", ls_req_ready); end
    @(posedge clk); #1;
    ls_req_valid = 0; mem_gnt = 1;
    @(posedge clk); #1;
    mem_gnt = 0;
    @(negedge clk);
    checks++; if ({busy, mem_req} !== 2'b10) begin errors++; $display("FAIL midwait_state: got %b exp 10", {busy, mem_req}); end
    @(posedge clk); #1;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1; mem_rvalid = 1; mem_rdata = 32'hFACE_0001;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({if_rsp_valid, ls_rsp_valid, busy, mem_req, if_rsp_data, ls_rsp_data} !== '0) begin
        errors++;
        $display("FAIL midwait_discard: got %h exp 0", {if_rsp_valid, ls_rsp_valid, busy, mem_req, if_rsp_data, ls_rsp_data});
      end
      @(posedge clk); #1;
      mem_rvalid = 0;
    end
    do_txn(0, 1, 32'h0, 32'h0000_0408, 0, 32'h0, 4'h0, 32'h0A0B_0C0D, 0, 0, 0);
    test_idle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_starvation();
    test_stalled_memory();
    test_back_to_back();
    test_random();
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
